// File: rtl/sdspi_responder_if.sv
// Pin and byte-handshake bundle between the sdspi master / SD card model side
// and the card-end SPI responder.
interface sdspi_responder_if;
    logic       spiCS;
    logic       spiSCLK;
    logic       spiMOSI;
    logic       spiMISO;
    logic [7:0] rxDATA;
    logic       rxVALID;
    logic [7:0] txDATA;
    logic       txLOAD;
    logic       txREADY;
    logic       txUNDER;
    logic       csACTIVE;

    modport slave (
        input  spiCS, spiSCLK, spiMOSI, txDATA, txLOAD,
        output spiMISO, rxDATA, rxVALID, txREADY, txUNDER, csACTIVE
    );

    modport master (
        output spiCS, spiSCLK, spiMOSI, txDATA, txLOAD,
        input  spiMISO, rxDATA, rxVALID, txREADY, txUNDER, csACTIVE
    );
endinterface

// File: rtl/sdspi_responder.sv
// Card-end SPI responder (CPOL=1, CPHA=1, MSB first): oversamples the SPI pins in
// the clk domain and exchanges whole bytes with an SD card model.
module sdspi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    sdspi_responder_if.slave bus
);
    typedef enum logic {DESELECT, SELECT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic       sclk_q;
    logic       sclk_s, mosi_s, cs_s;
    logic       sclk_fall, sclk_rise;
    logic       active, byte_start, take_hold, underflow;

    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [6:0] rx_shift;
    logic [7:0] hold;
    logic [7:0] rx_data;
    logic       tx_ready, miso, rx_valid, tx_under;

    // Presetting the synchronizers to 1 makes reset look like SCLK idle, CS deasserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '1;
            mosi_sync <= '1;
            cs_sync   <= '1;
            sclk_q    <= 1'b1;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spiSCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spiMOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spiCS};
            sclk_q    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_q & ~sclk_s;
    assign sclk_rise = ~sclk_q & sclk_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DESELECT;
        else     state <= state_next;
    end

    // CS rising while selected drops the engine in that same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next = state;
        active     = 1'b0;
        case (state)
            DESELECT: if (!cs_s) state_next = SELECT;
            SELECT: begin
                if (cs_s) state_next = DESELECT;
                else      active     = 1'b1;
            end
        endcase
        byte_start = active & sclk_fall & (bit_cnt == 3'd7);
        take_hold  = byte_start & ~tx_ready;
        underflow  = byte_start & tx_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 3'd7;
            tx_shift <= 8'hFF;
            rx_shift <= 7'h7F;
            hold     <= 8'hFF;
            rx_data  <= 8'hFF;
            tx_ready <= 1'b1;
            miso     <= 1'b1;
            rx_valid <= 1'b0;
            tx_under <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_under <= underflow;
            miso     <= active ? tx_shift[7] : 1'b1;

            if (!active) begin
                bit_cnt  <= 3'd7;
                tx_shift <= 8'hFF;
            end else begin
                if (sclk_fall) begin
                    if (bit_cnt == 3'd7) tx_shift <= tx_ready ? IDLE_BYTE : hold;
                    else                 tx_shift <= {tx_shift[6:0], 1'b1};
                end
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[5:0], mosi_s};
                    if (bit_cnt == 3'd0) begin
                        rx_data  <= {rx_shift, mosi_s};
                        rx_valid <= 1'b1;
                        bit_cnt  <= 3'd7;
                    end else begin
                        bit_cnt  <= bit_cnt - 3'd1;
                    end
                end
            end

            // Consumption needs a full register and a load needs an empty one, so
            // a load landing on an underflowing byte start is kept for the next byte.
            if (take_hold) begin
                tx_ready <= 1'b1;
            end else if (bus.txLOAD && tx_ready) begin
                hold     <= bus.txDATA;
                tx_ready <= 1'b0;
            end
        end
    end

    assign bus.spiMISO  = miso;
    assign bus.rxDATA   = rx_data;
    assign bus.rxVALID  = rx_valid;
    assign bus.txREADY  = tx_ready;
    assign bus.txUNDER  = tx_under;
    assign bus.csACTIVE = ~cs_s;
endmodule

// File: tb/tb_sdspi_responder.sv
// Bench for sdspi_responder: a behavioural SPI master drives whole frames and the
// results are compared against table entries, hand sequences and a queue model.
module tb_sdspi_responder;
    localparam int         HP   = 8;
    localparam int         SYNC = 2;
    localparam logic [7:0] IDLE = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdspi_responder_if bus ();

    sdspi_responder #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       do_load;
        logic [7:0] load_val;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        int         exp_under;
    } vec_t;

    vec_t vecs [6];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] rx_q [$];
    int         under_cnt = 0;
    int         miso_lat, rxv_lat;

    logic [7:0] model_hold [$];
    logic [7:0] exp_rx [$];
    int         model_under;

    logic [7:0] got, got2, d, m, e;
    int         nb, bad_idle;

    always @(negedge clk) begin
        if (bus.rxVALID === 1'b1) rx_q.push_back(bus.rxDATA);
        if (bus.txUNDER === 1'b1) under_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        rx_q.delete();
        under_cnt = 0;
    endtask

    // Master side: drive MOSI on the SCLK fall, sample MISO just before the rise.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'hFF;
        miso_lat = -1;
        rxv_lat  = -1;
        for (int b = 7; b > 7 - nbits; b--) begin
            bus.spiSCLK = 1'b0;
            bus.spiMOSI = mo[b];
            for (int k = 1; k <= HP; k++) begin
                @(negedge clk);
                if (b == 7 && miso_lat < 0 && bus.spiMISO === 1'b0) miso_lat = k;
            end
            mi[b] = bus.spiMISO;
            bus.spiSCLK = 1'b1;
            for (int k = 1; k <= HP; k++) begin
                @(negedge clk);
                if (b == 0 && rxv_lat < 0 && bus.rxVALID === 1'b1) rxv_lat = k;
            end
        end
    endtask

    task automatic cs_low();
        bus.spiCS = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic cs_high();
        bus.spiCS = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    task automatic tx_load(input logic [7:0] v);
        bus.txDATA = v;
        bus.txLOAD = 1'b1;
        @(negedge clk);
        bus.txLOAD = 1'b0;
    endtask

    // Reference: a one-deep holding slot; a load only lands in an empty slot,
    // and each byte takes the slot's content or the idle byte.
    task automatic model_load(input logic [7:0] v);
        if (model_hold.size() == 0) model_hold.push_back(v);
    endtask

    task automatic model_next(output logic [7:0] v);
        if (model_hold.size() != 0) begin
            v = model_hold.pop_front();
        end else begin
            v = IDLE;
            model_under++;
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] v);
        if (rx_q.size() != 0) check(name, rx_q.pop_front(), v);
        else                  check(name, 32'hDEAD, v);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h40, 8'hA5, 0};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1};
        vecs[2] = '{1'b1, 8'h00, 8'hAA, 8'h00, 0};
        vecs[3] = '{1'b1, 8'h5A, 8'h01, 8'h5A, 0};
        vecs[4] = '{1'b0, 8'h00, 8'h80, 8'hFF, 1};
        vecs[5] = '{1'b1, 8'hFF, 8'h7E, 8'hFF, 0};

        rst = 1'b1;
        bus.spiCS = 1'b1;
        bus.spiSCLK = 1'b1;
        bus.spiMOSI = 1'b1;
        bus.txLOAD = 1'b0;
        bus.txDATA = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", bus.spiMISO, 1'b1);
        check("rst_rxdata", bus.rxDATA, 8'hFF);
        check("rst_rxvalid", bus.rxVALID, 1'b0);
        check("rst_txready", bus.txREADY, 1'b1);
        check("rst_txunder", bus.txUNDER, 1'b0);
        check("rst_csactive", bus.csACTIVE, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // SCLK activity with CS high must be ignored.
        clear_obs();
        bad_idle = 0;
        for (int t = 0; t < 16; t++) begin
            bus.spiSCLK = ~bus.spiSCLK;
            bus.spiMOSI = 1'($urandom);
            repeat (HP) begin
                @(negedge clk);
                if (bus.spiMISO !== 1'b1) bad_idle++;
            end
        end
        check("desel_miso_low_cycles", bad_idle, 0);
        check("desel_rx_count", rx_q.size(), 0);
        check("desel_under", under_cnt, 0);
        check("desel_csactive", bus.csACTIVE, 1'b0);
        check("desel_txready", bus.txREADY, 1'b1);

        for (int i = 0; i < 6; i++) begin
            clear_obs();
            if (vecs[i].do_load) begin
                tx_load(vecs[i].load_val);
                check("vec_txready_loaded", bus.txREADY, 1'b0);
            end
            cs_low();
            check("vec_csactive", bus.csACTIVE, 1'b1);
            spi_xfer(vecs[i].mosi, 8, got);
            cs_high();
            check("vec_miso", got, vecs[i].exp_miso);
            check("vec_rx_count", rx_q.size(), 1);
            check_rx("vec_rxdata", vecs[i].mosi);
            check("vec_under", under_cnt, vecs[i].exp_under);
            check("vec_txready_after", bus.txREADY, 1'b1);
        end

        // Pin-to-pin latency of MISO after a fall and rxVALID after the 8th rise.
        clear_obs();
        tx_load(8'h3C);
        cs_low();
        spi_xfer(8'h81, 8, got);
        cs_high();
        check("lat_miso", miso_lat, SYNC + 2);
        check("lat_rxvalid", rxv_lat, SYNC + 1);
        check("lat_miso_byte", got, 8'h3C);
        check_rx("lat_rxdata", 8'h81);

        // Back-to-back bytes, load arriving during byte 1.
        clear_obs();
        cs_low();
        fork
            spi_xfer(8'h51, 8, got);
            begin
                repeat (3 * HP) @(negedge clk);
                tx_load(8'h12);
            end
        join
        spi_xfer(8'h00, 8, got2);
        cs_high();
        check("b2b_byte1", got, 8'hFF);
        check("b2b_byte2", got2, 8'h12);
        check("b2b_under", under_cnt, 1);
        check("b2b_rx_count", rx_q.size(), 2);
        check_rx("b2b_rx1", 8'h51);
        check_rx("b2b_rx2", 8'h00);

        // Load sampled on the very edge that consumes an empty register.
        clear_obs();
        cs_low();
        fork
            spi_xfer(8'hA0, 8, got);
            begin
                repeat (2) @(negedge clk);
                tx_load(8'h6D);
            end
        join
        spi_xfer(8'h0F, 8, got2);
        cs_high();
        check("same_cycle_byte1", got, 8'hFF);
        check("same_cycle_byte2", got2, 8'h6D);
        check("same_cycle_under", under_cnt, 1);

        // Partial byte discarded on CS deassertion.
        clear_obs();
        cs_low();
        spi_xfer(8'hC3, 5, got);
        cs_high();
        check("partial_rx_count", rx_q.size(), 0);
        cs_low();
        spi_xfer(8'h3C, 8, got);
        cs_high();
        check("partial_next_count", rx_q.size(), 1);
        check_rx("partial_next_rxdata", 8'h3C);

        // Asynchronous reset in the middle of a byte.
        cs_low();
        spi_xfer(8'hE1, 3, got);
        tx_load(8'h9B);
        check("arst_pre_csactive", bus.csACTIVE, 1'b1);
        check("arst_pre_txready", bus.txREADY, 1'b0);
        #2;
        rst = 1'b1;
        bus.spiCS = 1'b1;
        #1;
        check("arst_miso", bus.spiMISO, 1'b1);
        check("arst_rxdata", bus.rxDATA, 8'hFF);
        check("arst_rxvalid", bus.rxVALID, 1'b0);
        check("arst_txready", bus.txREADY, 1'b1);
        check("arst_txunder", bus.txUNDER, 1'b0);
        check("arst_csactive", bus.csACTIVE, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (HP) @(negedge clk);
        clear_obs();
        cs_low();
        spi_xfer(8'h77, 8, got);
        cs_high();
        check("arst_after_miso", got, IDLE);
        check("arst_after_count", rx_q.size(), 1);
        check_rx("arst_after_rxdata", 8'h77);

        // Randomized frames against the holding-slot model.
        model_hold.delete();
        for (int f = 0; f < 15; f++) begin
            repeat ($urandom_range(0, 2)) begin
                d = 8'($urandom);
                tx_load(d);
                model_load(d);
            end
            clear_obs();
            exp_rx.delete();
            model_under = 0;
            nb = $urandom_range(1, 3);
            cs_low();
            for (int i = 0; i < nb; i++) begin
                if (i > 0 && $urandom_range(0, 1) == 1) begin
                    d = 8'($urandom);
                    tx_load(d);
                    model_load(d);
                end
                m = 8'($urandom);
                model_next(e);
                spi_xfer(m, 8, got);
                check("rnd_miso", got, e);
                exp_rx.push_back(m);
            end
            cs_high();
            check("rnd_rx_count", rx_q.size(), exp_rx.size());
            while (exp_rx.size() != 0) check_rx("rnd_rxdata", exp_rx.pop_front());
            check("rnd_under", under_cnt, model_under);
            check("rnd_txready", bus.txREADY, model_hold.size() == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
